// File: rtl/rx_stream_correlator.sv
// Correlates each replayed sweep from the circular sample buffer against a fixed +/-1 code.
// Emits one signed result per sweep, a threshold detect pulse and running peak tracking.
module rx_stream_correlator #(
   parameter int                       MEMORY_LENGTH = 510,
   parameter int                       ACC_W         = 25,
   parameter logic [MEMORY_LENGTH-1:0] CODE          = {MEMORY_LENGTH{1'b1}}
) (
   input  logic                    crx_clk,
   input  logic                    rrx_rst,
   input  logic                    erx_en,
   input  logic                    sweep_start_i,
   input  logic signed [15:0]      data_i,
   input  logic [ACC_W-2:0]        threshold_i,
   input  logic                    peak_clr_i,
   output logic signed [ACC_W-1:0] corr_o,
   output logic                    corr_valid_o,
   output logic                    detect_o,
   output logic [ACC_W-2:0]        peak_abs_o,
   output logic [15:0]             peak_idx_o,
   output logic                    busy_o
);

   localparam int K_W   = $clog2(MEMORY_LENGTH);
   localparam int MAG_W = ACC_W - 1;
   localparam logic [K_W-1:0] K_LAST = K_W'(MEMORY_LENGTH - 1);

   typedef enum logic [1:0] {IDLE, ACCUM, FLUSH} state_t;

   state_t                  state_q, state_d;
   logic [K_W-1:0]          k_q, k_d;
   logic signed [16:0]      s1_q, s1_d;
   logic                    s1_first_q, s1_first_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic signed [ACC_W-1:0] corr_q, corr_d;
   logic                    valid_q, valid_d;
   logic                    detect_q, detect_d;
   logic [MAG_W-1:0]        peak_q, peak_d;
   logic [15:0]             idx_q, idx_d;
   logic [15:0]             cnt_q, cnt_d;

   logic [K_W-1:0]          k_sel;
   logic                    code_bit;
   logic signed [16:0]      data_ext;
   logic signed [16:0]      weighted;
   logic signed [ACC_W-1:0] s1_ext;
   logic signed [ACC_W-1:0] final_sum;
   logic [MAG_W-1:0]        final_abs;
   logic [MAG_W-1:0]        corr_abs;
   logic                    start_ok;
   logic                    result_ev;

   // A start always restarts at element 0, whatever the counter says.
   assign k_sel     = sweep_start_i ? '0 : k_q;
   assign code_bit  = CODE[k_sel];
   assign data_ext  = {data_i[15], data_i};
   assign weighted  = code_bit ? data_ext : -data_ext;
   assign s1_ext    = {{(ACC_W-17){s1_q[16]}}, s1_q};
   assign final_sum = acc_q + s1_ext;
   assign final_abs = final_sum[ACC_W-1] ? MAG_W'(-final_sum) : MAG_W'(final_sum);
   assign corr_abs  = corr_q[ACC_W-1] ? MAG_W'(-corr_q) : MAG_W'(corr_q);
   assign start_ok  = sweep_start_i & erx_en;

   always_comb begin
      state_d    = state_q;
      k_d        = k_q;
      s1_d       = s1_q;
      s1_first_d = s1_first_q;
      acc_d      = acc_q;
      corr_d     = corr_q;
      valid_d    = 1'b0;
      detect_d   = 1'b0;
      peak_d     = peak_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      result_ev  = 1'b0;

      if (!erx_en) begin
         state_d = IDLE;
      end else begin
         s1_d       = weighted;
         s1_first_d = sweep_start_i;
         k_d        = k_sel + K_W'(1);
         unique case (state_q)
            IDLE: begin
               if (start_ok) state_d = ACCUM;
            end
            ACCUM: begin
               acc_d = s1_first_q ? s1_ext : acc_q + s1_ext;
               if (start_ok)          state_d = ACCUM;
               else if (k_q == K_LAST) state_d = FLUSH;
            end
            FLUSH: begin
               // Last element is still in stage 1; fold it straight into the result.
               result_ev = 1'b1;
               corr_d    = final_sum;
               valid_d   = 1'b1;
               detect_d  = (final_abs >= threshold_i);
               cnt_d     = cnt_q + 16'd1;
               state_d   = start_ok ? ACCUM : IDLE;
            end
            default: state_d = IDLE;
         endcase
      end

      // Clear wins over the current peak, then any result on hand is reloaded as the peak.
      if (peak_clr_i) begin
         if (result_ev) begin
            peak_d = final_abs;
            idx_d  = cnt_q;
         end else if (valid_q) begin
            peak_d = corr_abs;
            idx_d  = cnt_q - 16'd1;
         end else begin
            peak_d = '0;
            idx_d  = '0;
         end
      end else if (result_ev && (final_abs > peak_q)) begin
         peak_d = final_abs;
         idx_d  = cnt_q;
      end
   end

   always_ff @(posedge crx_clk) begin
      if (rrx_rst) begin
         state_q    <= IDLE;
         k_q        <= '0;
         s1_q       <= '0;
         s1_first_q <= 1'b0;
         acc_q      <= '0;
         corr_q     <= '0;
         valid_q    <= 1'b0;
         detect_q   <= 1'b0;
         peak_q     <= '0;
         idx_q      <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         s1_q       <= s1_d;
         s1_first_q <= s1_first_d;
         acc_q      <= acc_d;
         corr_q     <= corr_d;
         valid_q    <= valid_d;
         detect_q   <= detect_d;
         peak_q     <= peak_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
      end
   end

   assign corr_o       = corr_q;
   assign corr_valid_o = valid_q;
   assign detect_o     = detect_q;
   assign peak_abs_o   = peak_q;
   assign peak_idx_o   = idx_q;
   // The result cycle still counts as busy.
   assign busy_o       = (state_q != IDLE) | valid_q;

endmodule
